dl_dff_reg: RTL and testbench

// - Parameterized D flip-flop / register-pipeline primitive of the design library.
// - Captures d on the rising clock edge and presents it on q after STAGES cycles.
// - Basic storage element under pipeline registers, state registers and sync stages.
// - Default configuration (WIDTH=1, STAGES=1) is a plain single-bit DFF.
//

---
 rtl/dl_dff_reg.sv | 63 ++++++
 tb/tb_dl_dff_reg.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/dl_dff_reg.sv
`default_nettype none
// ============================================================================
// Module   : dl_dff_reg
// Desc     : STAGES-deep, WIDTH-bit register pipeline with synchronous
//            active-low reset; common stage load enable when DL_DFF_CE_EN
//            is defined.
// Revision : 1.0
// ============================================================================
module dl_dff_reg #(
    parameter int               WIDTH     = 1,
    parameter int               STAGES    = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef DL_DFF_CE_EN
    input  logic             en,
`endif
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("dl_dff_reg: WIDTH must be >= 1");
        end
        if (STAGES < 1) begin : g_bad_stages
            $error("dl_dff_reg: STAGES must be >= 1");
        end
    endgenerate

    logic w_load;

`ifdef DL_DFF_CE_EN
    // One enable for all stages so the pipeline stalls as a unit.
    assign w_load = en;
`else
    assign w_load = 1'b1;
`endif

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic [WIDTH-1:0] w_din;
        logic [WIDTH-1:0] r_q;

        if (i == 0) begin : g_first
            assign w_din = d;
        end else begin : g_next
            assign w_din = g_stage[i-1].r_q;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_q <= RESET_VAL;
            end else if (w_load) begin
                r_q <= w_din;
            end
        end
    end

    assign q = g_stage[STAGES-1].r_q;

endmodule
`default_nettype wire

// File: tb/tb_dl_dff_reg.sv
`default_nettype none
// Bench for dl_dff_reg: two instances (1x1 and 8-bit x3 stages) driven with
// random data/reset, checked by a queue-based pipeline model and scoreboard.
module tb_dl_dff_reg;

    localparam int          S8  = 3;
    localparam logic [7:0]  RV8 = 8'hA5;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       d1;
    logic       q1;
    logic [7:0] d8;
    logic [7:0] q8;

    int total;
    int bad;

    // Model: each queue holds the values currently inside the pipeline,
    // oldest first; the oldest one is what q shows.
    logic       pipe1[$];
    logic [7:0] pipe8[$];
    logic       exp1[$];
    logic [7:0] exp8[$];

    dl_dff_reg #(.WIDTH(1), .STAGES(1), .RESET_VAL(1'b0)) u_dff1 (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef DL_DFF_CE_EN
        .en    (en),
`endif
        .d     (d1),
        .q     (q1)
    );

    dl_dff_reg #(.WIDTH(8), .STAGES(S8), .RESET_VAL(RV8)) u_dff8 (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef DL_DFF_CE_EN
        .en    (en),
`endif
        .d     (d8),
        .q     (q8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of stimulus on the negedge and predict the next posedge.
    task automatic step(input logic rst, input logic ld, input logic glitch,
                        input logic v1, input logic [7:0] v8);
        logic ld_eff;
        @(negedge clk);
        rst_n = ~rst;
        en    = ld;
        d1    = v1;
        d8    = v8;
`ifdef DL_DFF_CE_EN
        ld_eff = ld;
`else
        ld_eff = 1'b1;
`endif
        if (rst) begin
            pipe1 = {};
            pipe8 = {};
            pipe1.push_back(1'b0);
            for (int k = 0; k < S8; k++) pipe8.push_back(RV8);
        end else if (ld_eff && pipe8.size() > 0) begin
            pipe1.push_back(v1);
            void'(pipe1.pop_front());
            pipe8.push_back(v8);
            void'(pipe8.pop_front());
        end
        if (pipe8.size() > 0) begin
            exp1.push_back(pipe1[0]);
            exp8.push_back(pipe8[0]);
        end
        if (glitch && !rst) begin
            #2 rst_n = 1'b0;
            #2 rst_n = 1'b1;
        end
    endtask

    function automatic logic [7:0] r8();
        return 8'($urandom_range(0, 255));
    endfunction

    function automatic logic r1();
        return 1'($urandom_range(0, 1));
    endfunction

    // Monitor: compare both outputs just after every rising edge.
    initial begin
        logic       e1;
        logic [7:0] e8;
        forever begin
            @(posedge clk);
            #1;
            if (exp1.size() > 0) begin
                e1 = exp1.pop_front();
                total++;
                if (q1 !== e1) begin
                    bad++;
                    $display("FAIL q1 at %0t: got %b expected %b", $time, q1, e1);
                end
            end
            if (exp8.size() > 0) begin
                e8 = exp8.pop_front();
                total++;
                if (q8 !== e8) begin
                    bad++;
                    $display("FAIL q8 at %0t: got %h expected %h", $time, q8, e8);
                end
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        en    = 1'b1;
        d1    = 1'b1;
        d8    = 8'h00;

        // Reset held for two edges with d=1.
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'hFF);
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h5A);

        // Random toggling data.
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, r1(), r8());

        // Fixed pipeline sequence then random fill.
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h11);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h22);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h33);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, r1(), r8());

        // Reset while data is in flight.
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h44);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h55);
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h66);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, r1(), r8());

        // Reset pulses that never cover a rising edge.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, r1(), r8());

`ifdef DL_DFF_CE_EN
        // Stall, resume, then reset while stalled.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, r1(), r8());
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, r1(), r8());
        step(1'b1, 1'b0, 1'b0, r1(), r8());
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, r1(), r8());
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, r1(), r8());
`endif

        // Random mix of data, enable, resets and glitches.
        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 11) == 0), r1(), ($urandom_range(0, 7) == 0),
                 r1(), r8());
        end

        @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
